// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the async-FIFO read/write side controllers:
// FSM encoding and width helpers.
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Every field keeps at least one bit so degenerate parameters still elaborate.
    function automatic int width_of(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int lw_of(input int maxburst);
        return width_of(maxburst);
    endfunction

    function automatic int idw_of(input int nreq);
        return width_of(nreq);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] pick,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Scan farthest-first so the candidate closest to ptr overwrites the rest.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int c;
            c = (int'(ptr) + k) % NREQ;
            if (req[c]) begin
                pick    = '0;
                pick[c] = 1'b1;
                idx     = IDW'(c);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_burst_arbiter.sv
// Read-side burst scheduler: shares one FIFO read port among NREQ consumers,
// granting whole bursts round-robin and registering popped words with their owner id.
module fifo_rd_burst_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAXBURST  = 16,
    parameter int STALL_MAX = 64
) (
    input  logic                          rclk,
    input  logic                          rrst_n,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*lw_of(MAXBURST)-1:0] len,
    output logic [NREQ-1:0]               gnt,
    output logic                          done,
    output logic                          done_short,
    output logic                          rinc,
    input  logic                          rempty,
    input  logic [DSIZE-1:0]              rdata,
    output logic                          out_valid,
    output logic [DSIZE-1:0]              out_data,
    output logic [idw_of(NREQ)-1:0]       out_id,
    output logic                          out_last,
    input  logic                          out_ready
);

    localparam int LW  = lw_of(MAXBURST);
    localparam int IDW = idw_of(NREQ);
    localparam int SW  = width_of(STALL_MAX + 1);
    localparam logic [SW-1:0]  STALL_LAST = (STALL_MAX == 0) ? '0 : SW'(STALL_MAX - 1);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [IDW-1:0]  id;
    logic [IDW-1:0]  rr_ptr;
    logic [LW-1:0]   rem;
    logic [SW-1:0]   stall_cnt;
    logic [NREQ-1:0] pick;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            pop;
    logic            stall_hit;
    logic            burst_end;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Back-pressure blocks the pop but is not a stall; only rempty counts.
    assign pop       = (state == XFER) && !rempty && (!out_valid || out_ready);
    assign stall_hit = (state == XFER) && rempty && (STALL_MAX != 0) && (stall_cnt == STALL_LAST);
    assign burst_end = (pop && (rem == '0)) || stall_hit;
    assign rinc      = pop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any)  state_nxt = XFER;
            XFER:    if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            gnt        <= '0;
            id         <= '0;
            rr_ptr     <= '0;
            rem        <= '0;
            stall_cnt  <= '0;
            done       <= 1'b0;
            done_short <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            out_last   <= 1'b0;
        end else begin
            done       <= 1'b0;
            done_short <= 1'b0;

            if (state == IDLE && pick_any) begin
                gnt       <= pick;
                id        <= pick_idx;
                rem       <= len[pick_idx*LW +: LW];
                stall_cnt <= '0;
            end

            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= rdata;
                out_id    <= id;
                out_last  <= (rem == '0);
                rem       <= (rem == '0) ? '0 : rem - 1'b1;
                stall_cnt <= '0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == XFER && rempty && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;

            if (burst_end) begin
                gnt        <= '0;
                done       <= 1'b1;
                done_short <= stall_hit;
                rr_ptr     <= (id == LAST_ID) ? '0 : id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_burst_arbiter.sv
// Directed bench for fifo_rd_burst_arbiter: a FIFO model feeds the main instance
// (STALL_MAX=4); a second instance (STALL_MAX=0) covers the never-abort case.
module tb_fifo_rd_burst_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int LW    = 4;

    logic               rclk = 1'b0;
    logic               rrst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic               done, done_short, rinc, rempty;
    logic [DSIZE-1:0]   rdata;
    logic               out_valid, out_last, out_ready;
    logic [DSIZE-1:0]   out_data;
    logic [1:0]         out_id;

    logic [NREQ-1:0]    req2;
    logic [NREQ*LW-1:0] len2;
    logic [NREQ-1:0]    gnt2;
    logic               done2, done_short2, rinc2;
    logic               out_valid2, out_last2;
    logic [DSIZE-1:0]   out_data2;
    logic [1:0]         out_id2;

    always #5 rclk = ~rclk;

    fifo_rd_burst_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(16), .STALL_MAX(4)) u_dut (
        .rclk(rclk), .rrst_n(rrst_n), .req(req), .len(len), .gnt(gnt),
        .done(done), .done_short(done_short), .rinc(rinc), .rempty(rempty),
        .rdata(rdata), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_last(out_last), .out_ready(out_ready)
    );

    fifo_rd_burst_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(16), .STALL_MAX(0)) u_nostall (
        .rclk(rclk), .rrst_n(rrst_n), .req(req2), .len(len2), .gnt(gnt2),
        .done(done2), .done_short(done_short2), .rinc(rinc2), .rempty(1'b1),
        .rdata(8'h00), .out_valid(out_valid2), .out_data(out_data2), .out_id(out_id2),
        .out_last(out_last2), .out_ready(1'b1)
    );

    // FIFO model: words written by the stimulus, read pointer advanced on rinc.
    logic [DSIZE-1:0] fifo_mem [0:63];
    int rd_ptr = 0;
    int wr_cnt = 0;
    assign rempty = (rd_ptr == wr_cnt);
    assign rdata  = fifo_mem[rd_ptr % 64];

    always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 1;

    // Output/handshake monitor.
    logic [DSIZE-1:0] cap_data[$];
    int               cap_id[$];
    logic             cap_last[$];
    int               viol = 0;

    always @(posedge rclk) begin
        if (rrst_n && out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_id.push_back(int'(out_id));
            cap_last.push_back(out_last);
        end
        if (rinc && (rempty || (out_valid && !out_ready))) viol <= viol + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer model state, owned by the stimulus process.
    int              burst_cnt[NREQ];
    logic [NREQ-1:0] prev_gnt, last_gnt;
    bit              toggle_ready;
    int              cyc;
    int              grant_q[$];
    int              grant_cyc[$];
    int              done_cyc[$];
    int              done_cnt, short_cnt;

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic load(input logic [DSIZE-1:0] w);
        fifo_mem[wr_cnt % 64] = w;
        wr_cnt++;
    endtask

    task automatic step();
        @(negedge rclk);
        cyc++;
        if (gnt != '0 && prev_gnt == '0) begin
            grant_q.push_back(oh2idx(gnt));
            grant_cyc.push_back(cyc);
        end
        if (gnt != '0) last_gnt = gnt;
        prev_gnt = gnt;
        if (done) begin
            done_cnt++;
            if (done_short) short_cnt++;
            done_cyc.push_back(cyc);
            for (int i = 0; i < NREQ; i++)
                if (last_gnt[i] && burst_cnt[i] > 0) burst_cnt[i]--;
        end
        for (int i = 0; i < NREQ; i++) req[i] = (burst_cnt[i] > 0);
        out_ready = toggle_ready ? ~out_ready : 1'b1;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < budget && !idle; n++) begin
            step();
            idle = (gnt == '0) && !out_valid;
            for (int i = 0; i < NREQ; i++) if (burst_cnt[i] != 0) idle = 1'b0;
        end
        if (!idle) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_caps(input string tag, input int base, input int n,
                              input logic [DSIZE-1:0] d0, input int id_exp,
                              input bit last_on_final);
        check({tag, "_count"}, 32'(cap_data.size() - base), 32'(n));
        for (int k = 0; k < n && base + k < cap_data.size(); k++) begin
            check($sformatf("%s_data%0d", tag, k), 32'(cap_data[base+k]), 32'(d0 + DSIZE'(k)));
            check($sformatf("%s_id%0d", tag, k), 32'(cap_id[base+k]), 32'(id_exp));
            check($sformatf("%s_last%0d", tag, k), 32'(cap_last[base+k]),
                  32'(last_on_final && k == n - 1));
        end
    endtask

    initial begin
        int base, gbase, dbase, sbase, bad;

        rrst_n = 1'b0;
        req = '0; len = '0; out_ready = 1'b1;
        req2 = '0; len2 = '0;
        prev_gnt = '0; last_gnt = '0; toggle_ready = 1'b0;
        cyc = 0; done_cnt = 0; short_cnt = 0;
        for (int i = 0; i < NREQ; i++) burst_cnt[i] = 0;

        repeat (2) @(negedge rclk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        rrst_n = 1'b1;

        // All four consumers, single-word bursts, two each: strict rotation from 0.
        for (int k = 0; k < 8; k++) load(8'h10 + 8'(k));
        base = cap_data.size(); gbase = grant_q.size();
        for (int i = 0; i < NREQ; i++) burst_cnt[i] = 2;
        len = '0;
        run_until_idle("t2", 200);
        check("t2_count", 32'(cap_data.size() - base), 32'd8);
        for (int k = 0; k < 8 && base + k < cap_data.size(); k++) begin
            check($sformatf("t2_grant%0d", k), 32'(grant_q[gbase+k]), 32'(k % 4));
            check($sformatf("t2_id%0d", k), 32'(cap_id[base+k]), 32'(k % 4));
            check($sformatf("t2_data%0d", k), 32'(cap_data[base+k]), 32'(8'h10 + k));
            check($sformatf("t2_last%0d", k), 32'(cap_last[base+k]), 32'd1);
        end

        // Consumer 2, four-word burst.
        load(8'hA0); load(8'hA1); load(8'hA2); load(8'hA3);
        base = cap_data.size(); dbase = done_cnt; sbase = short_cnt;
        len[2*LW +: LW] = 4'd3;
        burst_cnt[2] = 1;
        step();
        step();
        check("t1_gnt", 32'(gnt), 32'b0100);
        run_until_idle("t1", 50);
        check_caps("t1", base, 4, 8'hA0, 2, 1'b1);
        check("t1_done", 32'(done_cnt - dbase), 32'd1);
        check("t1_short", 32'(short_cnt - sbase), 32'd0);
        check("t1_latency", 32'(done_cyc[done_cyc.size()-1] - grant_cyc[grant_cyc.size()-1]), 32'd4);

        // Consumer 0, eight words, out_ready toggling.
        for (int k = 0; k < 8; k++) load(8'h30 + 8'(k));
        base = cap_data.size(); sbase = short_cnt;
        len[0 +: LW] = 4'd7;
        burst_cnt[0] = 1;
        toggle_ready = 1'b1;
        run_until_idle("t3", 100);
        toggle_ready = 1'b0;
        check_caps("t3", base, 8, 8'h30, 0, 1'b1);
        check("t3_short", 32'(short_cnt - sbase), 32'd0);
        check("t3_viol", 32'(viol), 32'd0);

        // Consumer 1 asks for six words but only two arrive; consumer 2 waits behind it.
        load(8'h41); load(8'h42);
        base = cap_data.size(); gbase = grant_q.size(); dbase = done_cnt; sbase = short_cnt;
        len[1*LW +: LW] = 4'd5;
        len[2*LW +: LW] = 4'd0;
        burst_cnt[1] = 1; burst_cnt[2] = 1;
        run_until_idle("t4", 100);
        check_caps("t4", base, 2, 8'h41, 1, 1'b0);
        check("t4_grant0", 32'(grant_q[gbase]), 32'd1);
        check("t4_grant1", 32'(grant_q[gbase+1]), 32'd2);
        check("t4_latency", 32'(done_cyc[done_cyc.size()-2] - grant_cyc[gbase]), 32'd6);
        check("t4_done", 32'(done_cnt - dbase), 32'd2);
        check("t4_short", 32'(short_cnt - sbase), 32'd2);

        // Reset in the middle of a consumer 3 burst.
        for (int k = 0; k < 8; k++) load(8'h60 + 8'(k));
        base = cap_data.size();
        len[3*LW +: LW] = 4'd7;
        burst_cnt[3] = 1;
        for (int n = 0; n < 50 && cap_data.size() - base < 2; n++) step();
        check("t6_pre_gnt", 32'(gnt), 32'b1000);
        check("t6_pre_data", 32'(out_data), 32'h62);
        #2 rrst_n = 1'b0;
        #1;
        check("t6_gnt", 32'(gnt), 32'd0);
        check("t6_rinc", 32'(rinc), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_data", 32'(out_data), 32'd0);
        check("t6_out_id", 32'(out_id), 32'd0);
        check("t6_out_last", 32'(out_last), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        wr_cnt = rd_ptr;
        for (int i = 0; i < NREQ; i++) burst_cnt[i] = 0;
        req = '0;
        @(negedge rclk);
        rrst_n = 1'b1;
        prev_gnt = '0; last_gnt = '0;
        load(8'h70); load(8'h71);
        base = cap_data.size(); gbase = grant_q.size();
        len = '0;
        burst_cnt[3] = 1; burst_cnt[0] = 1;
        run_until_idle("t6", 50);
        check("t6_grant0", 32'(grant_q[gbase]), 32'd0);
        check("t6_grant1", 32'(grant_q[gbase+1]), 32'd3);
        check("t6_id0", 32'(cap_id[base]), 32'd0);
        check("t6_id1", 32'(cap_id[base+1]), 32'd3);
        check("t6_data0", 32'(cap_data[base]), 32'h70);

        // Never-abort instance: FIFO permanently empty.
        req2 = 4'b0001;
        repeat (3) @(negedge rclk);
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge rclk);
            if (gnt2 != 4'b0001 || rinc2 || done2) bad++;
        end
        check("t5_bad_cycles", 32'(bad), 32'd0);
        check("t5_gnt", 32'(gnt2), 32'b0001);
        check("t5_out_valid", 32'(out_valid2), 32'd0);

        check("rinc_viol", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
